// File: rtl/display_sync_rx.sv
// display_sync_rx
// ---------------
// This block recovers active-area coordinates and frame and line strobes from a raw
// hsync/vsync/de stream. It measures the line and frame timing and raises `locked`
// once that timing has stayed the same for enough complete frames.
// Everything runs in the clk_pix domain. The inputs are synchronous to clk_pix, so the
// input stage is a two-register edge detector and not a metastability synchroniser.
//
// Ports
//   clk_pix, rst_pix_n   pixel clock; synchronous active-low reset
//   hsync, vsync         raw syncs; polarity set by H_POL / V_POL (1 = active-high)
//   de                   raw data enable, active-high
//   sx, sy               active-area column/row of the pixel flagged by de_o
//   de_o                 de delayed by two clocks; qualifies sx/sy/line/frame
//   line                 one-clock strobe on the first active pixel of each line
//   frame                one-clock strobe on the first active pixel of a frame
//   h_total, h_active    measured clocks per line / de-high clocks per line
//   v_total, v_active    measured lines per frame / active lines per frame
//   locked               timing stable for LOCK_FRAMES matching frames
//
// Stream semantics: de_o acts as a valid with no back-pressure. sx, sy, line and frame
// mean something only in cycles where de_o is high. The sink must take every flagged
// pixel.
//
// The lock FSM lives in `state` (UNLOCKED / MEASURE / LOCKED) and can be probed directly.
module display_sync_rx #(
    parameter int CORDW       = 16,
    parameter int H_POL       = 0,
    parameter int V_POL       = 0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             de_o,
    output logic             line,
    output logic             frame,
    output logic [CORDW-1:0] h_total,
    output logic [CORDW-1:0] h_active,
    output logic [CORDW-1:0] v_total,
    output logic [CORDW-1:0] v_active,
    output logic             locked
);

    localparam logic [CORDW-1:0] CMAX     = '1;
    localparam logic [4:0]       LOCK_TGT = 5'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        MEASURE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t state;

    // Every counter saturates at the top of its range and never wraps.
    function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] x);
        return (x == CMAX) ? x : x + CORDW'(1);
    endfunction

    // Syncs are normalised to active-high before the edge detectors.
    logic hs_in, vs_in;
    assign hs_in = (H_POL != 0) ? hsync : ~hsync;
    assign vs_in = (V_POL != 0) ? vsync : ~vsync;

    logic hs_q1, hs_q2, vs_q1, vs_q2, de_q1, de_q2;
    logic hs_le, vs_le, de_rise, de_fall;

    assign hs_le   = hs_q1 & ~hs_q2;
    assign vs_le   = vs_q1 & ~vs_q2;
    assign de_rise = de_q1 & ~de_q2;
    assign de_fall = ~de_q1 & de_q2;

    logic [CORDW-1:0] hcnt, dcnt, vcnt, acnt;
    logic [4*CORDW-1:0] prev_meas;
    logic [3:0] match_cnt;

    logic [CORDW-1:0] hcnt_nx, dcnt_nx, vcnt_line, acnt_line, vcnt_nx, acnt_nx;
    logic [CORDW-1:0] h_total_nx, h_active_nx, v_total_nx, v_active_nx;
    logic [CORDW-1:0] sx_nx, sy_nx;
    logic [4*CORDW-1:0] cur_meas;
    logic             meas_ok, watchdog;
    logic [4:0]       match_inc;

    always_comb begin
        hcnt_nx     = hs_le ? CORDW'(1) : sat_inc(hcnt);
        h_total_nx  = hs_le ? hcnt : h_total;

        dcnt_nx     = dcnt;
        if (de_rise)    dcnt_nx = CORDW'(1);
        else if (de_q1) dcnt_nx = sat_inc(dcnt);
        h_active_nx = de_fall ? dcnt : h_active;

        // A line or active line that ends in the same cycle as the vsync edge still
        // belongs to the frame that is closing.
        vcnt_line   = hs_le ? sat_inc(vcnt) : vcnt;
        acnt_line   = de_fall ? sat_inc(acnt) : acnt;
        v_total_nx  = vs_le ? vcnt_line : v_total;
        v_active_nx = vs_le ? acnt_line : v_active;
        vcnt_nx     = vs_le ? '0 : vcnt_line;
        acnt_nx     = vs_le ? '0 : acnt_line;

        sx_nx = sx;
        if (de_rise)    sx_nx = '0;
        else if (de_q1) sx_nx = sat_inc(sx);

        sy_nx = sy;
        if (vs_le)        sy_nx = '0;
        else if (de_fall) sy_nx = sat_inc(sy);

        cur_meas = {h_total_nx, h_active_nx, v_total_nx, v_active_nx};
        meas_ok  = (cur_meas == prev_meas) &&
                   (h_total_nx != '0) && (h_active_nx != '0) &&
                   (v_total_nx != '0) && (v_active_nx != '0);

        // A saturated hcnt or vcnt means an hsync or vsync edge has gone missing.
        watchdog  = (hcnt == CMAX) || (vcnt == CMAX);
        match_inc = {1'b0, match_cnt} + 5'd1;
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            hs_q1     <= 1'b0;
            hs_q2     <= 1'b0;
            vs_q1     <= 1'b0;
            vs_q2     <= 1'b0;
            de_q1     <= 1'b0;
            de_q2     <= 1'b0;
            hcnt      <= '0;
            dcnt      <= '0;
            vcnt      <= '0;
            acnt      <= '0;
            sx        <= '0;
            sy        <= '0;
            de_o      <= 1'b0;
            line      <= 1'b0;
            frame     <= 1'b0;
            h_total   <= '0;
            h_active  <= '0;
            v_total   <= '0;
            v_active  <= '0;
            prev_meas <= '0;
            match_cnt <= '0;
            locked    <= 1'b0;
            state     <= UNLOCKED;
        end else begin
            hs_q1 <= hs_in;
            hs_q2 <= hs_q1;
            vs_q1 <= vs_in;
            vs_q2 <= vs_q1;
            de_q1 <= de;
            de_q2 <= de_q1;

            hcnt     <= hcnt_nx;
            dcnt     <= dcnt_nx;
            vcnt     <= vcnt_nx;
            acnt     <= acnt_nx;
            h_total  <= h_total_nx;
            h_active <= h_active_nx;
            v_total  <= v_total_nx;
            v_active <= v_active_nx;

            // The pixel outputs come from the q1 stage, so they land two clocks after
            // de is sampled.
            sx    <= sx_nx;
            sy    <= sy_nx;
            de_o  <= de_q1;
            line  <= de_rise;
            frame <= de_rise && (sy_nx == '0);

            case (state)
                UNLOCKED: begin
                    locked <= 1'b0;
                    // The first vsync edge only opens a frame. Its snapshot is the
                    // reference for the first comparison.
                    if (vs_le) begin
                        state     <= MEASURE;
                        match_cnt <= '0;
                        prev_meas <= cur_meas;
                    end
                end
                MEASURE: begin
                    if (watchdog) begin
                        state     <= UNLOCKED;
                        match_cnt <= '0;
                    end else if (vs_le) begin
                        prev_meas <= cur_meas;
                        if (meas_ok) begin
                            match_cnt <= match_inc[3:0];
                            if (match_inc >= LOCK_TGT) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (watchdog || (vs_le && !meas_ok)) begin
                        state     <= UNLOCKED;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                    end else if (vs_le) begin
                        prev_meas <= cur_meas;
                    end
                end
                default: begin
                    state     <= UNLOCKED;
                    locked    <= 1'b0;
                    match_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_sync_rx.sv
// Testbench for display_sync_rx.
// A single scaled-down raster feeds two instances:
//   dut_a: CORDW=16 with active-low syncs. Its pixel stream goes through the scoreboard.
//   dut_b: CORDW=8 with active-high syncs, so counter saturation is reachable in a
//          short run.
// Raster: 24 clocks per line (16 active, hfp 1, hsync 2, hbp 5).
//         12 lines per frame (8 active, vfp 1, vsync 2, vbp 1).
module tb_display_sync_rx;

    localparam int HT  = 24;
    localparam int HA  = 16;
    localparam int HFP = 1;
    localparam int HSW = 2;
    localparam int VT  = 12;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VSW = 2;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n;
    logic hs_act, vs_act, de_in;
    logic hsync_a, vsync_a;
    assign hsync_a = ~hs_act;
    assign vsync_a = ~vs_act;

    logic [15:0] sx_a, sy_a, ht_a, ha_a, vt_a, va_a;
    logic        deo_a, line_a, frame_a, lock_a;
    logic [7:0]  sx_b, sy_b, ht_b, ha_b, vt_b, va_b;
    logic        deo_b, line_b, frame_b, lock_b;

    display_sync_rx #(.CORDW(16), .H_POL(0), .V_POL(0), .LOCK_FRAMES(2)) dut_a (
        .clk_pix(clk), .rst_pix_n(rst_n), .hsync(hsync_a), .vsync(vsync_a), .de(de_in),
        .sx(sx_a), .sy(sy_a), .de_o(deo_a), .line(line_a), .frame(frame_a),
        .h_total(ht_a), .h_active(ha_a), .v_total(vt_a), .v_active(va_a), .locked(lock_a)
    );

    display_sync_rx #(.CORDW(8), .H_POL(1), .V_POL(1), .LOCK_FRAMES(2)) dut_b (
        .clk_pix(clk), .rst_pix_n(rst_n), .hsync(hs_act), .vsync(vs_act), .de(de_in),
        .sx(sx_b), .sy(sy_b), .de_o(deo_b), .line(line_b), .frame(frame_b),
        .h_total(ht_b), .h_active(ha_b), .v_total(vt_b), .v_active(va_b), .locked(lock_b)
    );

    // Scoreboard entry: {expected cycle, frame, line, sy, sx}
    logic [65:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_sy = 16'd0;
    logic        vs_last = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: every pixel dut_a flags must match the oldest expected pixel.
    always @(negedge clk) begin
        logic [65:0] e;
        logic [65:0] got;
        if (deo_a === 1'b1) begin
            checks++;
            got = {cyc, frame_a, line_a, sy_a, sx_a};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pixel_unexpected: got %h expected none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL pixel: got %h expected %h", got, e);
                end
            end
        end
    end

    // Driver tasks
    task automatic drive_cycle(input logic h, input logic v, input logic d, input logic r);
        @(negedge clk);
        hs_act = h;
        vs_act = v;
        de_in  = d;
        rst_n  = r;
    endtask

    // cut removes that many clocks from the end of the back porch. rst_c is the column
    // at which reset pulses for one clock (-1 means no reset).
    task automatic drive_line(input int l, input bit vs_en, input int cut, input int rst_c);
        logic h, v, d;
        v = vs_en && (l >= VA + VFP) && (l < VA + VFP + VSW);
        for (int c = 0; c < HT - cut; c++) begin
            d = (l < VA) && (c < HA);
            h = (c >= HA + HFP) && (c < HA + HFP + HSW);
            drive_cycle(h, v, d, (c != rst_c));
            if (c == rst_c) exp_sy = 16'd0;
            if (v && !vs_last) exp_sy = 16'd0;
            vs_last = v;
            if (d) exp_q.push_back({cyc + 32'd2, (c == 0) && (exp_sy == 16'd0), (c == 0),
                                    exp_sy, 16'(c)});
            if (d && (c == HA - 1) && (exp_sy != 16'hFFFF)) exp_sy = exp_sy + 16'd1;
        end
    endtask

    task automatic run_frame(input bit vs_en, input logic la, input logic lb, input bit chk);
        for (int l = 0; l < VT; l++) begin
            drive_line(l, vs_en, 0, -1);
            if (chk && (l == VA + VFP)) begin
                check("lock_a", 32'(lock_a), 32'(la));
                check("lock_b", 32'(lock_b), 32'(lb));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_xy"},     32'({sx_a, sy_a}), 32'd0);
        check({tag, "_a_strobe"}, 32'({deo_a, line_a, frame_a, lock_a}), 32'd0);
        check({tag, "_a_h"},      32'({ht_a, ha_a}), 32'd0);
        check({tag, "_a_v"},      32'({vt_a, va_a}), 32'd0);
        check({tag, "_b_xyh"},    32'({sx_b, sy_b, ht_b, ha_b}), 32'd0);
        check({tag, "_b_rest"},   32'({vt_b, va_b, deo_b, line_b, frame_b, lock_b}), 32'd0);
    endtask

    task automatic check_meas(input string tag);
        check({tag, "_ht_a"}, 32'(ht_a), 32'd24);
        check({tag, "_ha_a"}, 32'(ha_a), 32'd16);
        check({tag, "_vt_a"}, 32'(vt_a), 32'd12);
        check({tag, "_va_a"}, 32'(va_a), 32'd8);
        check({tag, "_ht_b"}, 32'(ht_b), 32'd24);
        check({tag, "_ha_b"}, 32'(ha_b), 32'd16);
        check({tag, "_vt_b"}, 32'(vt_b), 32'd12);
        check({tag, "_va_b"}, 32'(va_b), 32'd8);
    endtask

    // Stimulus sequence
    initial begin
        hs_act = 1'b0;
        vs_act = 1'b0;
        de_in  = 1'b0;
        rst_n  = 1'b0;
        repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_zero("reset");

        // Initial lock: the third vsync edge locks.
        run_frame(1'b1, 1'b0, 1'b0, 1'b1);
        run_frame(1'b1, 1'b0, 1'b0, 1'b1);
        run_frame(1'b1, 1'b1, 1'b1, 1'b1);
        check_meas("lock");

        // Line 7 is 4 clocks short. The line-8 hsync edge captures 20, and that value
        // is still in h_total at the frame close.
        for (int l = 0; l < 7; l++) drive_line(l, 1'b1, 0, -1);
        drive_line(7, 1'b1, 4, -1);
        drive_line(8, 1'b1, 0, -1);
        check("cut_ht_a", 32'(ht_a), 32'd20);
        check("cut_ht_b", 32'(ht_b), 32'd20);
        check("cut_prelock_a", 32'(lock_a), 32'd1);
        drive_line(9, 1'b1, 0, -1);
        check("cut_unlock_a", 32'(lock_a), 32'd0);
        check("cut_unlock_b", 32'(lock_b), 32'd0);
        check("cut_restored_ht_a", 32'(ht_a), 32'd24);
        drive_line(10, 1'b1, 0, -1);
        drive_line(11, 1'b1, 0, -1);
        run_frame(1'b1, 1'b0, 1'b0, 1'b1);
        run_frame(1'b1, 1'b1, 1'b1, 1'b1);

        // One-clock reset during the line-3 back porch while locked.
        for (int l = 0; l < 3; l++) drive_line(l, 1'b1, 0, -1);
        drive_line(3, 1'b1, 0, 22);
        check_zero("midrst");
        for (int l = 4; l < VT; l++) drive_line(l, 1'b1, 0, -1);
        check("midrst_open_a", 32'(lock_a), 32'd0);
        run_frame(1'b1, 1'b0, 1'b0, 1'b1);
        run_frame(1'b1, 1'b1, 1'b1, 1'b1);

        // vsync held off for 34 frames. vcnt of the 8-bit instance saturates, so its
        // watchdog drops lock. The 16-bit instance does not saturate and stays locked.
        repeat (34) run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_lock_a", 32'(lock_a), 32'd1);
        check("hold_lock_b", 32'(lock_b), 32'd0);
        check("hold_vcnt_b", 32'(dut_b.vcnt), 32'd255);
        check("hold_sy_b", 32'(sy_b), 32'd255);
        check("hold_sy_a", 32'(sy_a), 32'd272);
        check("hold_vt_a_kept", 32'(vt_a), 32'd12);

        // vsync resumes. The long frame closes as a mismatch on dut_a, then both relock.
        run_frame(1'b1, 1'b0, 1'b0, 1'b1);
        check("long_vt_a", 32'(vt_a), 32'd420);
        check("long_va_a", 32'(va_a), 32'd280);
        check("long_vt_b", 32'(vt_b), 32'd255);
        check("long_va_b", 32'(va_b), 32'd255);
        run_frame(1'b1, 1'b0, 1'b0, 1'b1);
        run_frame(1'b1, 1'b1, 1'b1, 1'b1);
        check_meas("relock");

        repeat (10) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_sync_rx.md
Name: display_sync_rx

Overview:
Receive-side counterpart of the display timing generator. Takes raw hsync/vsync/de from a video source, such as a display timing generator output or a capture front end. It recovers per-pixel active-area coordinates and frame/line strobes, measures horizontal and vertical timing, and reports lock once the timing is stable. It sits in the clk_pix domain ahead of capture, scaler or checker logic.

Parameters:
CORDW, 16, width of coordinate and measurement outputs
H_POL, 0, hsync active level (0 = active-low, as 640x480p60)
V_POL, 0, vsync active level (0 = active-low)
LOCK_FRAMES, 2, consecutive identical complete frames needed to assert locked (1..15)

Ports:
clk_pix  input  1  pixel clock; sole clock
rst_pix_n  input  1  reset, synchronous, active-low
hsync  input  1  horizontal sync from source, polarity per H_POL
vsync  input  1  vertical sync from source, polarity per V_POL
de  input  1  data enable from source, active-high
sx  output  CORDW  active-area column of pixel flagged by de_o
sy  output  CORDW  active-area row of pixel flagged by de_o
de_o  output  1  delayed de, aligned with sx/sy
line  output  1  1-cycle strobe on first active pixel of each active line
frame  output  1  1-cycle strobe on first active pixel of each frame (sx=0, sy=0)
h_total  output  CORDW  measured clocks per line
h_active  output  CORDW  measured de-high clocks per line
v_total  output  CORDW  measured lines per frame
v_active  output  CORDW  measured active lines per frame
locked  output  1  timing stable

Behaviour:
- Reset (rst_pix_n=0 at clk_pix edge): all outputs 0, all counters 0, FSM -> UNLOCKED, match count 0, input pipeline cleared to inactive levels.
- Input stage: hsync/vsync normalised to active-high per H_POL/V_POL, registered twice (q1, q2).
  - Leading edge = q1 & !q2. de registered likewise.
  - No metastability synchroniser, because inputs are synchronous to clk_pix.
- Latency: sx, sy, de_o, line, frame appear exactly 2 cycles after the corresponding de input sample.
- Pixel and line counters:
  - sx = 0 on de rising edge, +1 per de-high cycle.
  - sy +1 on each de falling edge; sy = 0 on vsync leading edge.
  - line = de_o rising edge.
  - frame = line & (sy == 0).
- Horizontal measurement:
  - hcnt counts clocks, restarting at 1 on each hsync leading edge.
  - On that edge: h_total <= hcnt of the previous line.
  - h_active <= de-high run length, captured at de falling edge.
- Vertical measurement:
  - vcnt counts hsync leading edges; acnt counts de falling edges.
  - On vsync leading edge: v_total <= vcnt, v_active <= acnt, then both clear.
- Saturation: all counters saturate at 2^CORDW-1; they never wrap.
- Frame boundary: a vsync leading edge closes a frame. The first edge after reset or unlock opens a frame but produces no comparison.
- FSM:
  - UNLOCKED: on vsync leading edge -> MEASURE, clear match count.
  - MEASURE: at each frame close, compare the new {h_total, h_active, v_total, v_active} with the previous frame's values.
    - Equal and all nonzero: match count +1.
    - Otherwise: match count = 0.
    - When match count reaches LOCK_FRAMES-1 -> LOCKED.
  - LOCKED: locked=1. Any frame-close mismatch, or a watchdog expiry, -> UNLOCKED with locked=0 on the next cycle. Measurement outputs keep their last values.
- Watchdog: hcnt or vcnt saturating (no hsync or vsync edge for 2^CORDW-1 clocks or lines) forces UNLOCKED.
- Simultaneous events:
  - hsync and vsync leading edges in the same cycle: the line is counted into the closing frame before vcnt clears.
  - de falling edge in the same cycle as vsync leading edge: counted into the closing frame's v_active.
- Reset mid-frame: all state clears immediately. Lock needs LOCK_FRAMES+1 vsync leading edges after reset release.
- locked, h_total, h_active, v_total and v_active are registered and update only at edge events. There is no combinational path from the inputs to any output.

Test Plan:
- 640x480p60 timing (800x525 totals, 640x480 active, negative syncs), LOCK_FRAMES=2 -> after the third vsync leading edge: h_total=800, h_active=640, v_total=525, v_active=480; locked=1 within 2 cycles of that edge.
- Same stream, probe the active area -> de_o lags de by exactly 2 cycles; sx runs 0..639 per line; sy runs 0..479; frame asserts once per frame with sx=0, sy=0; line asserts 480 times per frame.
- While locked, shorten one line's horizontal back porch by 4 clocks -> h_total=796 captured; locked drops at the next frame close. Restored timing -> relock after 2 further matching frames.
- Hold vsync inactive indefinitely -> vcnt saturates at 65535; locked=0; sy stops at saturation with no wrap.
- Assert rst_pix_n=0 for 1 cycle mid-frame while locked -> next cycle all outputs 0, locked=0; relock after 3 vsync leading edges.
- H_POL=1, V_POL=1 with positive-polarity syncs of 1650x750 total, 1280x720 active -> h_total=1650, h_active=1280, v_total=750, v_active=720, locked=1.
